// File: rtl/sc_et_pkg.sv
// ============================================================================
// Module   : sc_et_pkg
// Purpose  : Shared types and helpers for the early-terminating SNG.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sc_et_pkg;

    localparam int SC_W  = 6;
    localparam int LEN_W = SC_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Reverse the low n bits of v; bits at n and above come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r[n - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

    // Trailing zeros within the low n bits; an all-zero field yields n.
    function automatic logic [31:0] tz_count(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = 32'(n);
        for (int i = 31; i >= 0; i--) begin
            if ((i < n) && v[i]) begin
                t = 32'(i);
            end
        end
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sc_et_len.sv
// ============================================================================
// Module   : sc_et_len
// Purpose  : Operand -> stream length L. With SC_ET_EN, L = 2^(W - tz(Bx));
//            otherwise L is the full 2^W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_et_len
    import sc_et_pkg::*;
#(
    parameter int W = SC_W
) (
    input  logic [W-1:0] bx,
    output logic [W:0]   len
);

`ifdef SC_ET_EN
    logic [31:0] tz;

    assign tz  = tz_count(32'(bx), W);
    assign len = (W + 1)'(1) << (32'(W) - tz);
`else
    logic unused_bx;

    assign unused_bx = ^bx;
    assign len       = (W + 1)'(1) << W;
`endif

endmodule

`default_nettype wire

// File: rtl/sc_et_sng.sv
// ============================================================================
// Module   : sc_et_sng
// Purpose  : Exact unipolar stochastic number generator with optional early
//            termination (macro SC_ET_EN) at the shortest exact length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_et_sng
    import sc_et_pkg::*;
#(
    parameter int W = SC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] Bx,
    output logic         bs,
    output logic         bs_valid,
    input  logic         bs_ready,
    output logic         bs_last,
    output logic [W:0]   len
);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] bx_q, bx_d;
    logic [W:0]   len_q, len_d;

    logic [W:0]   len_new;
    logic [31:0]  rev;
    logic         run;
    logic         beat;
    logic         accept;

    sc_et_len #(.W(W)) u_len (
        .bx  (Bx),
        .len (len_new)
    );

    // Bit-reversed counter spreads the ones evenly across any 2^k prefix.
    assign rev      = bitrev(32'(cnt_q), W);
    assign run      = (state_q == ST_RUN);
    assign bs_valid = run;
    assign bs       = run & (rev < 32'(bx_q));
    assign bs_last  = run & ({1'b0, cnt_q} == (len_q - 1'b1));
    assign beat     = bs_valid & bs_ready;
    assign in_ready = (state_q == ST_IDLE) | (beat & bs_last);
    assign accept   = in_valid & in_ready;
    assign len      = len_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bx_d    = bx_q;
        len_d   = len_q;
        if (accept) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            bx_d    = Bx;
            len_d   = len_new;
        end else if (beat) begin
            if (bs_last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bx_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bx_q    <= bx_d;
            len_q   <= len_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sc_et_sng.sv
// ============================================================================
// Module   : tb_sc_et_sng
// Purpose  : Directed self-checking bench for sc_et_sng; expectations track
//            the SC_ET_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_et_sng;

    localparam int W = 6;

`ifdef SC_ET_EN
    localparam logic [6:0]  L12 = 7'd16;
    localparam logic [63:0] M12 = 64'h0000_0000_0000_0111;
    localparam int          N12 = 3;
    localparam logic [6:0]  L48 = 7'd4;
    localparam logic [63:0] M48 = 64'h0000_0000_0000_0007;
    localparam int          N48 = 3;
    localparam logic [6:0]  L0  = 7'd1;
    localparam logic        IR0 = 1'b1;
`else
    localparam logic [6:0]  L12 = 7'd64;
    localparam logic [63:0] M12 = 64'h0111_0111_0111_0111;
    localparam int          N12 = 12;
    localparam logic [6:0]  L48 = 7'd64;
    localparam logic [63:0] M48 = 64'h7777_7777_7777_7777;
    localparam int          N48 = 48;
    localparam logic [6:0]  L0  = 7'd64;
    localparam logic        IR0 = 1'b0;
`endif
    localparam logic [63:0] M63 = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M3  = 64'h0000_0001_0001_0001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] Bx = '0;
    logic         bs;
    logic         bs_valid;
    logic         bs_ready = 1'b1;
    logic         bs_last;
    logic [W:0]   len;

    int tests = 0;
    int fails = 0;

    sc_et_sng #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Bx       (Bx),
        .bs       (bs),
        .bs_valid (bs_valid),
        .bs_ready (bs_ready),
        .bs_last  (bs_last),
        .len      (len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        Bx = v;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("offer_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [6:0] exp_len,
                           input logic [63:0] exp_mask, input int exp_ones,
                           input bit toggle);
        logic [63:0] mask;
        int          beat_n;
        int          last_at;
        int          cyc;
        bit          done;
        logic        prev_stall;
        logic        prev_bs;
        logic        prev_last;
        mask = '0;
        beat_n = 0;
        last_at = -1;
        cyc = 0;
        done = 1'b0;
        prev_stall = 1'b0;
        prev_bs = 1'b0;
        prev_last = 1'b0;
        chk({tag, "_len"}, 64'(len), 64'(exp_len));
        while (!done && cyc < 400) begin
            bs_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (prev_stall) begin
                chk({tag, "_hold_bs"}, 64'(bs), 64'(prev_bs));
                chk({tag, "_hold_last"}, 64'(bs_last), 64'(prev_last));
            end
            prev_stall = bs_valid && !bs_ready;
            prev_bs = bs;
            prev_last = bs_last;
            if (bs_valid && bs_ready) begin
                if (bs && beat_n < 64) mask[beat_n] = 1'b1;
                if (bs_last) begin
                    last_at = beat_n;
                    done = 1'b1;
                end
                beat_n++;
            end else if (!bs_valid) begin
                done = 1'b1;
            end
            tick();
            cyc++;
        end
        bs_ready = 1'b1;
        chk({tag, "_last_beat"}, 64'(last_at), 64'(int'(exp_len) - 1));
        chk({tag, "_beats"}, 64'(beat_n), 64'(int'(exp_len)));
        chk({tag, "_mask"}, mask, exp_mask);
        chk({tag, "_ones"}, 64'($countones(mask)), 64'(exp_ones));
    endtask

    initial begin
        logic seen;

        tick();
        tick();
        chk("rst_bs_valid", 64'(bs_valid), 64'(0));
        chk("rst_bs", 64'(bs), 64'(0));
        chk("rst_bs_last", 64'(bs_last), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_len", 64'(len), 64'(0));
        rst_n = 1'b1;
        tick();

        offer(6'b001100);
        collect("bx12", L12, M12, N12, 1'b0);
        chk("bx12_idle_valid", 64'(bs_valid), 64'(0));
        chk("bx12_idle_ready", 64'(in_ready), 64'(1));

        offer(6'b110000);
        collect("bx48", L48, M48, N48, 1'b0);

        offer(6'b000000);
        chk("bx0_first_last", 64'(bs_last), 64'(IR0));
        chk("bx0_first_ready", 64'(in_ready), 64'(IR0));
        collect("bx0", L0, 64'(0), 0, 1'b0);
        chk("bx0_after_ready", 64'(in_ready), 64'(1));

        // Second operand waits on in_valid for the whole first stream.
        in_valid = 1'b1;
        Bx = 6'b111111;
        tick();
        Bx = 6'b000011;
        chk("b2b_busy_ready", 64'(in_ready), 64'(0));
        collect("bx63", 7'd64, M63, 63, 1'b0);
        in_valid = 1'b0;
        chk("b2b_no_bubble", 64'(bs_valid), 64'(1));
        collect("bx3", 7'd64, M3, 3, 1'b0);

        offer(6'b001100);
        collect("stall", L12, M12, N12, 1'b1);

        offer(6'b001100);
        repeat (10) tick();
        chk("abort_pre_valid", 64'(bs_valid), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("abort_bs", 64'(bs), 64'(0));
        chk("abort_bs_valid", 64'(bs_valid), 64'(0));
        chk("abort_bs_last", 64'(bs_last), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_len", 64'(len), 64'(0));
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | bs_last | bs_valid;
        end
        chk("abort_quiet", 64'(seen), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
